// File: rtl/float_arb_pkg.sv
// Shared sizing helpers for the shared-multiplier arbiter.
package float_arb_pkg;

    // Packed float width: sign + exponent + fraction.
    function automatic int calc_w(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Requester ID width, never narrower than one bit.
    function automatic int calc_id_bits(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at the pointer, plus the pointer register.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_block,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_vld,
    output logic [ID_BITS-1:0] o_grant_id
);

    logic [ID_BITS-1:0] r_ptr;
    logic               w_found;
    logic [ID_BITS-1:0] w_id;
    logic [ID_BITS-1:0] w_pos;
    int                 w_sum;

    // First valid requester at or after the pointer, wrapping; blocked grants are suppressed.
    always_comb begin
        w_found = 1'b0;
        w_id    = '0;
        w_pos   = '0;
        w_sum   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = int'(r_ptr) + off;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_pos = ID_BITS'(w_sum);
            if (!w_found && i_valid[w_pos]) begin
                w_found = 1'b1;
                w_id    = w_pos;
            end
        end
        if (i_block) begin
            w_found = 1'b0;
        end
    end

    assign o_grant_vld = w_found;
    assign o_grant_id  = w_id;
    assign o_grant     = w_found ? (NUM_REQ'(1) << w_id) : '0;

    // Pointer moves just past the granted requester, otherwise holds.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_id) == NUM_REQ - 1) ? '0 : w_id + 1'b1;
        end
    end

endmodule

// File: rtl/float_multiply_arbiter.sv
// Shares one non-stalling pipelined multiplier among several requesters and
// returns each product tagged with the requester ID on a broadcast bus.
module float_multiply_arbiter
    import float_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int EXP           = 8,
    parameter  int FRAC          = 23,
    parameter  int TRAILING_BITS = 2,
    parameter  int MUL_LATENCY   = 3,
    localparam int W             = calc_w(EXP, FRAC),
    localparam int ID_BITS       = calc_id_bits(NUM_REQ)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_reqValid,
    output logic [NUM_REQ-1:0]       o_reqReady,
    input  logic [NUM_REQ*W-1:0]     i_reqA,
    input  logic [NUM_REQ*W-1:0]     i_reqB,
    input  logic                     i_drain,
    output logic [W-1:0]             o_mulInA,
    output logic [W-1:0]             o_mulInB,
    input  logic [W-1:0]             i_mulOut,
    input  logic [TRAILING_BITS-1:0] i_mulTrailingBits,
    input  logic                     i_mulSticky,
    input  logic                     i_mulIsNan,
    output logic                     o_resValid,
    output logic [ID_BITS-1:0]       o_resId,
    output logic [W-1:0]             o_resData,
    output logic [TRAILING_BITS-1:0] o_resTrailingBits,
    output logic                     o_resSticky,
    output logic                     o_resIsNan,
    output logic                     o_idle
);

    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
    } tag_t;

    tag_t                     r_tag [0:MUL_LATENCY];
    logic [W-1:0]             r_mulInA;
    logic [W-1:0]             r_mulInB;
    logic                     r_resValid;
    logic [ID_BITS-1:0]       r_resId;
    logic [W-1:0]             r_resData;
    logic [TRAILING_BITS-1:0] r_resTrailingBits;
    logic                     r_resSticky;
    logic                     r_resIsNan;

    logic [NUM_REQ-1:0]       w_grant;
    logic                     w_grant_vld;
    logic [ID_BITS-1:0]       w_grant_id;
    logic [W-1:0]             w_opA;
    logic [W-1:0]             w_opB;
    logic                     w_any_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr_arbiter (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_block     (i_drain | i_reset),
        .i_valid     (i_reqValid),
        .o_grant     (w_grant),
        .o_grant_vld (w_grant_vld),
        .o_grant_id  (w_grant_id)
    );

    // Operand mux for the granted requester.
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_BITS'(i)) begin
                w_opA = i_reqA[i*W +: W];
                w_opB = i_reqB[i*W +: W];
            end
        end
    end

    // Issue register: granted operands and a fresh tag, or +0.0 and an empty tag.
    always_ff @(posedge i_clock) begin
        if (i_reset || !w_grant_vld) begin
            r_mulInA <= '0;
            r_mulInB <= '0;
            r_tag[0] <= '0;
        end else begin
            r_mulInA <= w_opA;
            r_mulInB <= w_opB;
            r_tag[0] <= '{valid: 1'b1, id: w_grant_id};
        end
    end

    // Tag pipe shifts every cycle; the last stage lines up with the multiplier output.
    always_ff @(posedge i_clock) begin
        for (int k = 1; k <= MUL_LATENCY; k++) begin
            r_tag[k] <= i_reset ? '0 : r_tag[k-1];
        end
    end

    // Result register; payload holds while no result is valid.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_resValid        <= 1'b0;
            r_resId           <= '0;
            r_resData         <= '0;
            r_resTrailingBits <= '0;
            r_resSticky       <= 1'b0;
            r_resIsNan        <= 1'b0;
        end else begin
            r_resValid <= r_tag[MUL_LATENCY].valid;
            if (r_tag[MUL_LATENCY].valid) begin
                r_resId           <= r_tag[MUL_LATENCY].id;
                r_resData         <= i_mulOut;
                r_resTrailingBits <= i_mulTrailingBits;
                r_resSticky       <= i_mulSticky;
                r_resIsNan        <= i_mulIsNan;
            end
        end
    end

    // Any operation still travelling through the tag pipe.
    always_comb begin
        w_any_tag = 1'b0;
        for (int k = 0; k <= MUL_LATENCY; k++) begin
            w_any_tag = w_any_tag | r_tag[k].valid;
        end
    end

    assign o_reqReady        = w_grant;
    assign o_mulInA          = r_mulInA;
    assign o_mulInB          = r_mulInB;
    assign o_resValid        = r_resValid;
    assign o_resId           = r_resId;
    assign o_resData         = r_resData;
    assign o_resTrailingBits = r_resTrailingBits;
    assign o_resSticky       = r_resSticky;
    assign o_resIsNan        = r_resIsNan;
    assign o_idle            = !w_any_tag && !r_resValid && !w_grant_vld;

endmodule

// File: tb/tb_float_multiply_arbiter.sv
// Bench for float_multiply_arbiter: a stub multiplier, a cycle-level model of
// grants and result timing, and directed scenarios with literal expectations.
module tb_float_multiply_arbiter;

    localparam int NR  = 4;
    localparam int W   = 32;
    localparam int TBW = 2;
    localparam int LAT = 3;
    localparam int IDB = 2;
    localparam int DEPTH = 2048;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              drain = 1'b0;
    logic [NR-1:0]     reqValid = '0;
    logic [NR-1:0]     reqReady;
    logic [NR*W-1:0]   reqA;
    logic [NR*W-1:0]   reqB;
    logic [W-1:0]      ta [0:NR-1];
    logic [W-1:0]      tbv [0:NR-1];
    logic [W-1:0]      mulInA, mulInB, mulOut;
    logic [TBW-1:0]    mulTrailingBits;
    logic              mulSticky, mulIsNan;
    logic              resValid;
    logic [IDB-1:0]    resId;
    logic [W-1:0]      resData;
    logic [TBW-1:0]    resTrailingBits;
    logic              resSticky, resIsNan, idle;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    assign reqA = {ta[3], ta[2], ta[1], ta[0]};
    assign reqB = {tbv[3], tbv[2], tbv[1], tbv[0]};

    always #5 clock = ~clock;

    float_multiply_arbiter dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_reqValid        (reqValid),
        .o_reqReady        (reqReady),
        .i_reqA            (reqA),
        .i_reqB            (reqB),
        .i_drain           (drain),
        .o_mulInA          (mulInA),
        .o_mulInB          (mulInB),
        .i_mulOut          (mulOut),
        .i_mulTrailingBits (mulTrailingBits),
        .i_mulSticky       (mulSticky),
        .i_mulIsNan        (mulIsNan),
        .o_resValid        (resValid),
        .o_resId           (resId),
        .o_resData         (resData),
        .o_resTrailingBits (resTrailingBits),
        .o_resSticky       (resSticky),
        .o_resIsNan        (resIsNan),
        .o_idle            (idle)
    );

    // Single-precision multiply, truncating; returns {isNan, sticky, trailing[1:0], result}.
    function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        logic [47:0] p;
        int          e;
        logic [22:0] fr;
        logic [1:0]  tr;
        logic        st;
        s     = a[31] ^ b[31];
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        zer_a = (a[30:23] == 8'h00);
        zer_b = (b[30:23] == 8'h00);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a))
            return {1'b1, 1'b0, 2'b00, 32'h7FC00000};
        if (inf_a || inf_b)
            return {4'b0000, s, 8'hFF, 23'd0};
        if (zer_a || zer_b)
            return {4'b0000, s, 31'd0};
        p = {25'd1, a[22:0]} * {25'd1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            fr = p[46:24]; tr = p[23:22]; st = |p[21:0]; e = e + 1;
        end else begin
            fr = p[45:23]; tr = p[22:21]; st = |p[20:0];
        end
        return {1'b0, st, tr, s, e[7:0], fr};
    endfunction

    // Stub multiplier: three register stages from mulIn to mulOut.
    logic [35:0] st1 = '0, st2 = '0, st3 = '0;
    always @(posedge clock) begin
        st1 <= fmul(mulInA, mulInB);
        st2 <= st1;
        st3 <= st2;
    end
    assign {mulIsNan, mulSticky, mulTrailingBits, mulOut} = st3;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: expected results and issue operands indexed by the cycle they become visible.
    bit          exp_rv [0:DEPTH-1];
    int          exp_id [0:DEPTH-1];
    logic [31:0] exp_a  [0:DEPTH-1];
    logic [31:0] exp_b  [0:DEPTH-1];
    logic [31:0] iss_a  [0:DEPTH-1];
    logic [31:0] iss_b  [0:DEPTH-1];
    int          m_ptr = 0;

    initial begin
        for (int j = 0; j < DEPTH; j++) begin
            exp_rv[j] = 1'b0; exp_id[j] = 0; exp_a[j] = '0; exp_b[j] = '0;
            iss_a[j] = '0; iss_b[j] = '0;
        end
    end

    // Compare process: check every output against the model in the middle of each cycle.
    always @(negedge clock) begin
        int           g;
        int           idx;
        logic [NR-1:0] er;
        logic [35:0]  ex;
        logic         ei;
        g = -1;
        if (!reset && !drain) begin
            for (int off = 0; off < NR; off++) begin
                idx = (m_ptr + off) % NR;
                if (g < 0 && reqValid[idx]) g = idx;
            end
        end
        if (chk_en) begin
            er = (g >= 0) ? (NR'(1) << g) : '0;
            check("reqReady", reqReady, er);
            check("mulInA", mulInA, iss_a[cyc]);
            check("mulInB", mulInB, iss_b[cyc]);
            check("resValid", resValid, exp_rv[cyc]);
            if (exp_rv[cyc]) begin
                ex = fmul(exp_a[cyc], exp_b[cyc]);
                check("resId", resId, exp_id[cyc]);
                check("resData", resData, ex[31:0]);
                check("resTrailingBits", resTrailingBits, ex[33:32]);
                check("resSticky", resSticky, ex[34]);
                check("resIsNan", resIsNan, ex[35]);
            end
            ei = (g < 0);
            for (int j = 0; j <= LAT + 1; j++) if (exp_rv[cyc + j]) ei = 1'b0;
            check("idle", idle, ei);
        end
        if (reset) begin
            m_ptr = 0;
            for (int j = 1; j <= 8; j++) begin
                exp_rv[cyc + j] = 1'b0;
                iss_a[cyc + j]  = '0;
                iss_b[cyc + j]  = '0;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            iss_a[cyc + 1] = ta[g];
            iss_b[cyc + 1] = tbv[g];
            exp_rv[cyc + LAT + 2] = 1'b1;
            exp_id[cyc + LAT + 2] = g;
            exp_a[cyc + LAT + 2]  = ta[g];
            exp_b[cyc + LAT + 2]  = tbv[g];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic quiet(input int n);
        reqValid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        bit found;
        int run, maxrun, cnt;
        bit prev;
        bit idle_seen;
        int ids [$];
        logic [35:0] r;

        for (int i = 0; i < NR; i++) begin ta[i] = '0; tbv[i] = '0; end

        // Pin the model multiplier on hand-computed values.
        r = fmul(32'h40000000, 32'h40400000);
        check("model_2x3", r, {4'b0000, 32'h40C00000});
        r = fmul(32'h7F800000, 32'h00000000);
        check("model_inf_x_0", r, {1'b1, 3'b000, 32'h7FC00000});

        // Reset state.
        tick();
        chk_en = 1'b1;
        reset  = 1'b0;
        #1;
        check("rst_resValid", resValid, 1'b0);
        check("rst_resData", resData, 32'h0);
        check("rst_resId", resId, 2'd0);
        check("rst_mulInA", mulInA, 32'h0);
        check("rst_idle", idle, 1'b1);
        tick();

        // Single request from requester 1: 2.0 * 3.0.
        ta[1] = 32'h40000000; tbv[1] = 32'h40400000;
        reqValid = 4'b0010;
        #1;
        check("t1_reqReady", reqReady, 4'b0010);
        tick();
        reqValid = '0;
        n = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            n++;
            if (resValid) found = 1'b1;
        end
        check("t1_found", found, 1'b1);
        check("t1_latency", n, 4);
        check("t1_resId", resId, 2'd1);
        check("t1_resData", resData, 32'h40C00000);
        tick();
        check("t1_one_cycle", resValid, 1'b0);
        check("t1_idle", idle, 1'b1);

        // All four requesters for eight cycles, starting from pointer 0.
        pulse_reset();
        run = 0; maxrun = 0;
        for (int t = 0; t < 18; t++) begin
            if (t < 8) begin
                for (int i = 0; i < NR; i++) begin
                    ta[i]  = {1'b0, 8'(127 + i), 23'(t * 1000 + 7)};
                    tbv[i] = {1'b0, 8'd128, 23'(i * 12345 + t)};
                end
                reqValid = 4'b1111;
            end else begin
                reqValid = '0;
            end
            tick();
            if (resValid) begin
                ids.push_back(int'(resId));
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("t2_count", ids.size(), 8);
        check("t2_consecutive", maxrun, 8);
        for (int i = 0; i < ids.size() && i < 8; i++) check("t2_order", ids[i], i % 4);

        // Requesters 0 and 2 only: grants alternate.
        pulse_reset();
        ta[0] = 32'h3F800000; tbv[0] = 32'h40000000;
        ta[2] = 32'hC0400000; tbv[2] = 32'h3FC00000;
        reqValid = 4'b0101;
        for (int t = 0; t < 6; t++) begin
            #1;
            check("t3_alternate", reqReady, (t % 2 == 0) ? 4'b0001 : 4'b0100);
            tick();
        end
        quiet(7);

        // Two operations in flight, then drain with every requester valid.
        ta[0] = 32'h41000000; tbv[0] = 32'h40800000;
        reqValid = 4'b0001;
        #1;
        check("t4_single_a", reqReady, 4'b0001);
        tick();
        #1;
        check("t4_single_b", reqReady, 4'b0001);
        tick();
        drain = 1'b1;
        reqValid = 4'b1111;
        cnt = 0; prev = 1'b0; idle_seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            #1;
            check("t4_drain_ready", reqReady, 4'b0000);
            if (resValid) cnt++;
            if (prev && !resValid && !idle_seen) begin
                check("t4_idle_after", idle, 1'b1);
                idle_seen = 1'b1;
            end
            prev = resValid;
            tick();
        end
        check("t4_results", cnt, 2);
        check("t4_idle_seen", idle_seen, 1'b1);
        drain = 1'b0;
        #1;
        check("t4_resume", reqReady, 4'b0010);
        tick();
        quiet(7);

        // Reset with three operations in flight discards them all.
        reqValid = 4'b1111;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reqValid = '0;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (resValid) cnt++;
            tick();
        end
        check("t5_no_results", cnt, 0);
        reqValid = 4'b1111;
        #1;
        check("t5_first_grant", reqReady, 4'b0001);
        tick();
        quiet(7);

        // Requester 3: inf * 0 produces NaN.
        ta[3] = 32'h7F800000; tbv[3] = 32'h00000000;
        reqValid = 4'b1000;
        #1;
        check("t6_reqReady", reqReady, 4'b1000);
        tick();
        reqValid = '0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (resValid) found = 1'b1;
        end
        check("t6_found", found, 1'b1);
        check("t6_resIsNan", resIsNan, 1'b1);
        check("t6_resData", resData, 32'h7FC00000);
        check("t6_resId", resId, 2'd3);
        quiet(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
